// File: rtl/low_priority_decoder_2_4_seq.sv
// Sequenced 2:4 decoder: accepts a 2-bit low-priority index over valid/ready
// and holds the matching one-hot strobe for HOLD_CYCLES clocks.
module low_priority_decoder_2_4_seq #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       Clock_In,
    input  logic       Reset_n_In,
    input  logic       Enable_In,
    input  logic       Abort_In,
    input  logic [1:0] Encoded_Value_In,
    input  logic       Valid_In,
    output logic       Ready_Out,
    output logic       Data_0_Out,
    output logic       Data_1_Out,
    output logic       Data_2_Out,
    output logic       Data_3_Out,
    output logic       Busy_Out,
    output logic       Done_Out
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       data_q, data_d;
    logic             cnt_zero;
    logic             kill;
    logic             accept;
    logic [3:0]       decoded;

    assign cnt_zero  = (cnt_q == '0);
    assign kill      = ~Enable_In | Abort_In;
    assign Ready_Out = Reset_n_In & ~kill & ((state_q == IDLE) | cnt_zero);
    assign accept    = Valid_In & Ready_Out;
    assign Done_Out  = (state_q == HOLD) & cnt_zero;
    assign Busy_Out  = (state_q == HOLD);

    assign Data_0_Out = data_q[0];
    assign Data_1_Out = data_q[1];
    assign Data_2_Out = data_q[2];
    assign Data_3_Out = data_q[3];

    // Encoder mapping is inverted: code 3 selects Data_0, code 0 selects Data_3.
    always_comb begin
        decoded = 4'b0000;
        case (Encoded_Value_In)
            2'd3:    decoded = 4'b0001;
            2'd2:    decoded = 4'b0010;
            2'd1:    decoded = 4'b0100;
            2'd0:    decoded = 4'b1000;
            default: decoded = 4'b0000;
        endcase
    end

    // Next state: kill beats accept, accept beats the natural end of a hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
            data_d  = 4'b0000;
        end else if (accept) begin
            state_d = HOLD;
            cnt_d   = CNT_LOAD;
            data_d  = decoded;
        end else if (state_q == HOLD) begin
            if (cnt_zero) begin
                state_d = IDLE;
                data_d  = 4'b0000;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule
